// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and default constants for the key debouncer.
//   key_state_e  : per-key FSM state encoding
//   *_DEF        : default parameter values for the top and key_channel
//   cnt_width()  : repeat-counter width for a given first-repeat delay
package key_debounce_pkg;

    // Per-key debounce FSM states
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESSED     = 2'd1,
        HOLD_REPEAT = 2'd2
    } key_state_e;

    localparam int unsigned N_KEYS_DEF      = 4;
    localparam int unsigned DEPTH_DEF       = 4;
    localparam int unsigned REPEAT_DLY_DEF  = 32;
    localparam int unsigned REPEAT_RATE_DEF = 8;

    // Counter must be able to hold REPEAT_DLY itself
    function automatic int unsigned cnt_width(input int unsigned dly);
        return $clog2(dly + 1);
    endfunction

endpackage : key_debounce_pkg

// File: rtl/key_debounce_pulse_channel.sv
// key_channel: one debounced key.
// Raw pin -> 2-FF synchroniser -> DEPTH-bit sample shift register (LSB newest)
// -> press/release FSM with registered level and one-cycle pulses.
// Optional auto-repeat counter when KEY_DEBOUNCE_REPEAT_EN is defined.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   sample_en_i    : one-cycle strobe on each debounce tick edge
//   key_raw_i      : raw asynchronous pin, active-high when pressed
//   key_level_o    : debounced level
//   key_press_o    : one-cycle pulse on accepted press (and auto-repeat)
//   key_release_o  : one-cycle pulse on accepted release
module key_channel
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF
`ifdef KEY_DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY  = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_RATE = REPEAT_RATE_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en_i,
    input  logic key_raw_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o
);

    logic [1:0]       sync_q;
    logic [DEPTH-1:0] shift_q;
    logic             dec_en_q;
    key_state_e       state_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             all_ones_c;
    logic             all_zeros_c;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int unsigned CNT_W = cnt_width(REPEAT_DLY);
    logic [CNT_W-1:0] cnt_q;
`endif

    // Synchroniser, sample shift register and decision strobe
    always_ff @(posedge clk or negedge rst_n) begin : p_sample
        if (!rst_n) begin
            sync_q   <= 2'b00;
            shift_q  <= '0;
            dec_en_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_raw_i};
            dec_en_q <= sample_en_i;
            if (sample_en_i) begin
                shift_q <= {shift_q[DEPTH-2:0], sync_q[1]};
            end
        end
    end

    assign all_ones_c  = &shift_q;
    assign all_zeros_c = ~|shift_q;

    // Decision FSM: evaluated only in the cycle after a new sample was shifted in
    always_ff @(posedge clk or negedge rst_n) begin : p_fsm
        if (!rst_n) begin
            state_q   <= RELEASED;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            cnt_q     <= '0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (dec_en_q) begin
                case (state_q)
                    RELEASED: begin
                        if (all_ones_c) begin
                            state_q <= PRESSED;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end
                    end
`ifdef KEY_DEBOUNCE_REPEAT_EN
                    PRESSED: begin
                        if (all_zeros_c) begin
                            state_q   <= RELEASED;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                        end else if (cnt_q == CNT_W'(REPEAT_DLY - 1)) begin
                            // REPEAT_DLY-th tick since the press: first repeat
                            state_q <= HOLD_REPEAT;
                            press_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    HOLD_REPEAT: begin
                        if (all_zeros_c) begin
                            state_q   <= RELEASED;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                        end else if (cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
                            press_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`else
                    PRESSED: begin
                        if (all_zeros_c) begin
                            state_q   <= RELEASED;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        // Unreachable encoding: recover quietly to RELEASED
                        state_q <= RELEASED;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;

endmodule : key_channel

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: N-key push-button debouncer with press/release pulses.
// Edge-detects the slow divider tick (same clk domain) into a one-cycle
// sample strobe shared by all key channels, and concatenates channel outputs.
// Optional auto-repeat is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick_in      : divided debounce tick level
//   key_raw      : [N_KEYS] raw pins, active-high when pressed
//   key_level    : [N_KEYS] debounced levels
//   key_press    : [N_KEYS] one-cycle press (and auto-repeat) pulses
//   key_release  : [N_KEYS] one-cycle release pulses
module key_debounce_pulse
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS      = N_KEYS_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned REPEAT_DLY  = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_RATE = REPEAT_RATE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_in,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    logic tick_prev_q;
    logic sample_en_c;

    // Elaboration-time parameter sanity
    if (DEPTH < 2 || DEPTH > 8 || REPEAT_DLY == 0 || REPEAT_RATE == 0 ||
        REPEAT_RATE > REPEAT_DLY) begin : g_bad_param
        $error("key_debounce_pulse: illegal DEPTH/REPEAT_DLY/REPEAT_RATE");
    end

    // Tick rising-edge detect; a tick already high at reset release counts as an edge
    always_ff @(posedge clk or negedge rst_n) begin : p_tick
        if (!rst_n) begin
            tick_prev_q <= 1'b0;
        end else begin
            tick_prev_q <= tick_in;
        end
    end

    assign sample_en_c = tick_in & ~tick_prev_q;

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
        key_channel #(
            .DEPTH       (DEPTH)
`ifdef KEY_DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE)
`endif
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
            .sample_en_i   (sample_en_c),
            .key_raw_i     (key_raw[i]),
            .key_level_o   (key_level[i]),
            .key_press_o   (key_press[i]),
            .key_release_o (key_release[i])
        );
    end

endmodule : key_debounce_pulse

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse: DEPTH=4, N_KEYS=4, tick_in
// toggling every 4 clk. Expected pulse events are queued when stimulus is
// driven; a monitor queues observed pulse events; each test pops and compares.
module tb_key_debounce_pulse;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic [3:0] key_raw;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        int         lo;
        int         hi;
    } exp_t;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        int         cyc;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    int         errors;
    int         checks;
    int         cyc;
    logic [3:0] prev_press;
    logic [3:0] prev_rel;

    key_debounce_pulse #(
        .N_KEYS      (4),
        .DEPTH       (4),
        .REPEAT_DLY  (32),
        .REPEAT_RATE (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: tick level toggles every 4 clk, changes on falling edges
    initial begin
        tick_in = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            tick_in = ~tick_in;
        end
    end

    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitor: records every pulse event and checks pulse shape
    always @(posedge clk) begin
        #1;
        if ((key_press | key_release) != 4'b0000) begin
            checks++;
            if ((key_press & key_release) != 4'b0000 || (key_press & prev_press) != 4'b0000 ||
                (key_release & prev_rel) != 4'b0000) begin
                errors++;
                $display("FAIL pulse_shape: press=%b release=%b prev_press=%b prev_release=%b at cyc %0d, required disjoint single-cycle pulses",
                         key_press, key_release, prev_press, prev_rel, cyc);
            end
            obs_q.push_back('{press: key_press, rel: key_release, cyc: cyc});
        end
        prev_press = key_press;
        prev_rel   = key_release;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the falling edge on which tick_in rises
    task automatic align_tick();
        @(posedge tick_in);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        key_raw = 4'b0000;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(100);
        checks++;
        if (key_level !== 4'b0000) begin
            errors++;
            $display("FAIL reset_level: got %b, required 0000", key_level);
        end
        checks++;
        if (key_press !== 4'b0000 || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got press=%b release=%b, required 0000/0000", key_press, key_release);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_events: got %0d pulse events, required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_single_press();
        exp_t e;
        obs_t o;
        int   c;
        align_tick();
        c = cyc;
        key_raw[0] = 1'b1;
        exp_q.push_back('{press: 4'b0001, rel: 4'b0000, lo: c + 33, hi: c + 35});
        wait_clk(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL single_press: no event, required press=%b release=%b in cyc %0d..%0d", e.press, e.rel, e.lo, e.hi);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== e.press || o.rel !== e.rel || o.cyc < e.lo || o.cyc > e.hi) begin
                    errors++;
                    $display("FAIL single_press: got press=%b release=%b at cyc %0d, required press=%b release=%b in cyc %0d..%0d",
                             o.press, o.rel, o.cyc, e.press, e.rel, e.lo, e.hi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL single_press_extra: got %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        checks++;
        if (key_level !== 4'b0001) begin
            errors++;
            $display("FAIL single_press_level: got %b, required 0001", key_level);
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        obs_t o;
        int   c;
        align_tick();
        key_raw[1] = 1'b1;
        wait_clk(8);
        key_raw[1] = 1'b0;
        wait_clk(8);
        key_raw[1] = 1'b1;
        wait_clk(8);
        key_raw[1] = 1'b0;
        wait_clk(8);
        c = cyc;
        key_raw[1] = 1'b1;
        exp_q.push_back('{press: 4'b0010, rel: 4'b0000, lo: c + 33, hi: c + 35});
        wait_clk(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL bounce: no event, required press=%b release=%b in cyc %0d..%0d", e.press, e.rel, e.lo, e.hi);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== e.press || o.rel !== e.rel || o.cyc < e.lo || o.cyc > e.hi) begin
                    errors++;
                    $display("FAIL bounce: got press=%b release=%b at cyc %0d, required press=%b release=%b in cyc %0d..%0d",
                             o.press, o.rel, o.cyc, e.press, e.rel, e.lo, e.hi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_extra: got %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        checks++;
        if (key_level !== 4'b0011) begin
            errors++;
            $display("FAIL bounce_level: got %b, required 0011", key_level);
        end
    endtask

    task automatic test_release();
        exp_t e;
        obs_t o;
        int   c;
        // Two-tick glitch low during the hold must be ignored
        align_tick();
        key_raw[0] = 1'b0;
        wait_clk(16);
        key_raw[0] = 1'b1;
        wait_clk(48);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_no_release: got %0d events, required 0", obs_q.size());
        end
        obs_q.delete();
        checks++;
        if (key_level !== 4'b0011) begin
            errors++;
            $display("FAIL glitch_level: got %b, required 0011", key_level);
        end
        align_tick();
        c = cyc;
        key_raw[0] = 1'b0;
        exp_q.push_back('{press: 4'b0000, rel: 4'b0001, lo: c + 33, hi: c + 35});
        wait_clk(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL release: no event, required press=%b release=%b in cyc %0d..%0d", e.press, e.rel, e.lo, e.hi);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== e.press || o.rel !== e.rel || o.cyc < e.lo || o.cyc > e.hi) begin
                    errors++;
                    $display("FAIL release: got press=%b release=%b at cyc %0d, required press=%b release=%b in cyc %0d..%0d",
                             o.press, o.rel, o.cyc, e.press, e.rel, e.lo, e.hi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL release_extra: got %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        checks++;
        if (key_level !== 4'b0010) begin
            errors++;
            $display("FAIL release_level: got %b, required 0010", key_level);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        obs_t o;
        int   c;
        align_tick();
        c = cyc;
        key_raw = 4'b0000;
        exp_q.push_back('{press: 4'b0000, rel: 4'b0010, lo: c + 33, hi: c + 35});
        wait_clk(40);
        align_tick();
        c = cyc;
        key_raw = 4'b1111;
        exp_q.push_back('{press: 4'b1111, rel: 4'b0000, lo: c + 33, hi: c + 35});
        wait_clk(40);
        checks++;
        if (key_level !== 4'b1111) begin
            errors++;
            $display("FAIL simultaneous_level: got %b, required 1111", key_level);
        end
        align_tick();
        c = cyc;
        key_raw = 4'b0000;
        exp_q.push_back('{press: 4'b0000, rel: 4'b1111, lo: c + 33, hi: c + 35});
        wait_clk(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL simultaneous: no event, required press=%b release=%b in cyc %0d..%0d", e.press, e.rel, e.lo, e.hi);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== e.press || o.rel !== e.rel || o.cyc < e.lo || o.cyc > e.hi) begin
                    errors++;
                    $display("FAIL simultaneous: got press=%b release=%b at cyc %0d, required press=%b release=%b in cyc %0d..%0d",
                             o.press, o.rel, o.cyc, e.press, e.rel, e.lo, e.hi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL simultaneous_extra: got %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        checks++;
        if (key_level !== 4'b0000) begin
            errors++;
            $display("FAIL simultaneous_release_level: got %b, required 0000", key_level);
        end
    endtask

    task automatic test_repeat();
        exp_t e;
        obs_t o;
        int   c;
        int   c2;
        align_tick();
        c = cyc;
        key_raw[2] = 1'b1;
        exp_q.push_back('{press: 4'b0100, rel: 4'b0000, lo: c + 33, hi: c + 35});
`ifdef KEY_DEBOUNCE_REPEAT_EN
        // Repeats 32, 40 and 48 ticks (8 clk each) after the initial press
        exp_q.push_back('{press: 4'b0100, rel: 4'b0000, lo: c + 289, hi: c + 291});
        exp_q.push_back('{press: 4'b0100, rel: 4'b0000, lo: c + 353, hi: c + 355});
        exp_q.push_back('{press: 4'b0100, rel: 4'b0000, lo: c + 417, hi: c + 419});
`endif
        wait_clk(420);
        checks++;
        if (key_level !== 4'b0100) begin
            errors++;
            $display("FAIL hold_level: got %b, required 0100", key_level);
        end
        c2 = cyc;
        key_raw[2] = 1'b0;
        exp_q.push_back('{press: 4'b0000, rel: 4'b0100, lo: c2 + 24, hi: c2 + 40});
        wait_clk(80);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL hold_repeat: no event, required press=%b release=%b in cyc %0d..%0d", e.press, e.rel, e.lo, e.hi);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== e.press || o.rel !== e.rel || o.cyc < e.lo || o.cyc > e.hi) begin
                    errors++;
                    $display("FAIL hold_repeat: got press=%b release=%b at cyc %0d, required press=%b release=%b in cyc %0d..%0d",
                             o.press, o.rel, o.cyc, e.press, e.rel, e.lo, e.hi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL hold_repeat_extra: got %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        int   c;
        int   r;
        align_tick();
        c = cyc;
        key_raw[3] = 1'b1;
        exp_q.push_back('{press: 4'b1000, rel: 4'b0000, lo: c + 33, hi: c + 35});
        wait_clk(40);
        checks++;
        if (key_level !== 4'b1000) begin
            errors++;
            $display("FAIL pre_reset_level: got %b, required 1000", key_level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (key_level !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_outputs: got level=%b press=%b release=%b, required all 0000",
                     key_level, key_press, key_release);
        end
        wait_clk(3);
        rst_n = 1'b1;
        r = cyc;
        // Key still held: re-accepted as a new press, never a release
        exp_q.push_back('{press: 4'b1000, rel: 4'b0000, lo: r + 27, hi: r + 36});
        wait_clk(45);
        checks++;
        if (key_level !== 4'b1000) begin
            errors++;
            $display("FAIL reaccept_level: got %b, required 1000", key_level);
        end
        align_tick();
        c = cyc;
        key_raw[3] = 1'b0;
        exp_q.push_back('{press: 4'b0000, rel: 4'b1000, lo: c + 33, hi: c + 35});
        wait_clk(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL reset_mid: no event, required press=%b release=%b in cyc %0d..%0d", e.press, e.rel, e.lo, e.hi);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== e.press || o.rel !== e.rel || o.cyc < e.lo || o.cyc > e.hi) begin
                    errors++;
                    $display("FAIL reset_mid: got press=%b release=%b at cyc %0d, required press=%b release=%b in cyc %0d..%0d",
                             o.press, o.rel, o.cyc, e.press, e.rel, e.lo, e.hi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_extra: got %0d unexpected events, required 0", obs_q.size());
        end
        obs_q.delete();
        checks++;
        if (key_level !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_final_level: got %b, required 0000", key_level);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        key_raw    = 4'b0000;
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        prev_press = 4'b0000;
        prev_rel   = 4'b0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_repeat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_debounce_pulse

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Consumer of the free-running divider's slow debounce tick: turns N raw, bouncing push-button inputs into clean debounced levels plus single-`clk`-cycle press and release pulses.
- Sits between the board pins and the control FSMs (stopwatch/scan logic), which must only ever see one press pulse per physical press.
- The tick input is a divided level, a register bit of the same `clk` domain; this block edge-detects it internally.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEPTH, 4, consecutive equal samples required to accept a new level (2..8).
- REPEAT_DLY, 32, ticks a key must be held before the first auto-repeat pulse (only with REPEAT_EN).
- REPEAT_RATE, 8, ticks between subsequent auto-repeat pulses (only with REPEAT_EN).

Ports:
- clk  input  1  global clock.
- rst_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  divided debounce clock level from the divider; `clk` domain.
- key_raw  input  N_KEYS  raw button pins; asynchronous, active-high when pressed.
- key_level  output  N_KEYS  debounced key state.
- key_press  output  N_KEYS  one-cycle pulse on accepted press (and auto-repeat).
- key_release  output  N_KEYS  one-cycle pulse on accepted release.

Behaviour:
- Reset: asynchronous, active-low, rst_n; clock clk. On reset:
  - tick_prev=0, synchronisers=0, shift registers=0.
  - key_level=0, key_press=0, key_release=0.
  - Per-key FSM=RELEASED; repeat counters=0.
- Tick detect:
  - sample_en = tick_in & ~tick_prev, registered tick_prev each `clk`.
  - If tick_in is high at reset release, the first cycle counts as an edge.
- Sync: each key_raw bit passes through a 2-FF synchroniser. No other logic touches key_raw.
- Sampling: on a sample_en cycle, shift the synced bit into a per-key DEPTH-bit shift register (LSB = newest).
- Decision (cycle after the shift):
  - Shift reg all-ones with FSM RELEASED: go to PRESSED; key_level<=1; key_press<=1 for exactly one cycle.
  - Shift reg all-zeros with FSM not RELEASED: go to RELEASED; key_level<=0; key_release<=1 for one cycle.
  - Mixed contents: no change.
- Latency: from the first stable synced sample, acceptance occurs on the DEPTH-th sample_en, with outputs valid 1 `clk` later. Total worst case from the pin is 2 + DEPTH tick periods + 2 clk.
- Pulses: key_press and key_release are never both high for one key. Each is high only one cycle, independent of the tick period.
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous pulses.
- Bounce shorter than DEPTH samples never changes key_level.
- Reset mid-press: all outputs drop to 0 immediately. No release pulse is generated.
- A key held through reset release is re-accepted as a new press after DEPTH samples.

Optional Feature:
- Macro: KEY_DEBOUNCE_REPEAT_EN.
- Defined:
  - FSM states are RELEASED, PRESSED, HOLD_REPEAT.
  - In PRESSED, count sample_en ticks. When the count reaches REPEAT_DLY, emit a key_press pulse, go to HOLD_REPEAT, and clear the counter.
  - In HOLD_REPEAT, emit key_press every REPEAT_RATE ticks.
  - key_level stays 1 throughout.
  - Release is accepted from either state. The counter is cleared on release.
  - Counter width is clog2(REPEAT_DLY+1).
- Undefined:
  - FSM states are RELEASED and PRESSED only; no counters are synthesised.
  - Exactly one key_press pulse per accepted press.

Decomposition:
- Package key_debounce_pkg holds:
  - FSM state encoding (RELEASED=2'd0, PRESSED=2'd1, HOLD_REPEAT=2'd2).
  - Default constants for DEPTH, REPEAT_DLY, REPEAT_RATE.
- Sub-module key_channel: one per key via generate. It contains the synchroniser, shift register, FSM and optional repeat counter.
- The top level holds only the tick edge detector and output concatenation.

Test Plan:
Bench settings: DEPTH=4, tick_in toggles every 4 clk (edge every 8 clk), N_KEYS=4.
- Reset with key_raw=4'b0000 for 100 clk -> key_level=0 and no pulses. Assert rst_n low mid-run -> all outputs 0 within the same cycle.
- key_raw[0] goes 0->1 and holds -> exactly one key_press[0] pulse, ≤5 ticks later; key_level[0]=1; other keys unaffected.
- key_raw[1] bounces 1,0,1,0 (one tick each), then stays 1 -> no pulse during the bounce; one key_press[1] after 4 stable ticks.
- Release key_raw[0] after stable hold -> one key_release[0] pulse; key_level[0]=0 after 4 zero samples. A glitch of 2 ticks at 0 during the hold -> no release.
- key_raw=4'b1111 simultaneously -> key_press=4'b1111 in the same cycle, one cycle wide.
- With KEY_DEBOUNCE_REPEAT_EN, REPEAT_DLY=32, REPEAT_RATE=8: hold key 2 -> initial press, then press pulses at +32, +40, +48 ticks; release stops them. Without the macro: a single press only.
